// File: rtl/icache_dm_if.sv
// Bus bundle for the direct-mapped instruction cache.
// The slave modport is the cache itself. It takes fetch requests and ROM
// responses, and drives instructions, ROM requests and the performance counters.
// The master modport is the CPU/ROM environment around it.
interface icache_dm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_flush;
  logic [DATA_W-1:0] cpu_instr;
  logic              cpu_ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  modport slave (
    input  cpu_req, cpu_addr, cpu_flush, mem_rdata, mem_ack,
    output cpu_instr, cpu_ready, mem_req, mem_addr, hit_count, miss_count
  );

  modport master (
    output cpu_req, cpu_addr, cpu_flush, mem_rdata, mem_ack,
    input  cpu_instr, cpu_ready, mem_req, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache in front of a word-wide ROM.
// A hit returns the word one cycle after the request.
// A miss refills the whole line one beat at a time, in order, and then returns
// the requested word during the RESP cycle.
// A flush clears every valid bit. A refill that is hit by a flush still
// completes, but its line stays invalid.
module icache_dm #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic          iCLK,
  input  logic          iRST,
  icache_dm_if.slave    bus
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  // Controller state and the captured request
  logic [1:0]        state_reg;
  logic [TAG_W-1:0]  cap_tag_reg;
  logic [IDX_W-1:0]  cap_idx_reg;
  logic [OFF_W-1:0]  cap_off_reg;
  logic [OFF_W-1:0]  beat_reg;
  logic              flushed_reg;
  logic [DATA_W-1:0] crit_reg;

  // Outputs
  logic              cpu_ready_reg;
  logic [DATA_W-1:0] cpu_instr_reg;
  logic [31:0]       hit_count_reg;
  logic [31:0]       miss_count_reg;

  // Storage
  logic [LINES-1:0]  valid_reg;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES*WORDS_PER_LINE];

  // Fields of the incoming fetch address
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;
  logic              addr_lsb_unused;

  // Decoded controller events
  logic              lookup_hit;
  logic              accept;
  logic              miss_start;
  logic              refill_ack;
  logic              last_beat;
  logic              fill_done;
  logic              crit_beat;

  assign req_tag         = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign req_idx         = bus.cpu_addr[2+OFF_W +: IDX_W];
  assign req_off         = bus.cpu_addr[2 +: OFF_W];
  // The byte-within-word bits play no part in a word fetch
  assign addr_lsb_unused = ^bus.cpu_addr[1:0];

  assign lookup_hit = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
  // A flush wins over a fetch presented in the same cycle
  assign accept     = (state_reg == S_IDLE) && bus.cpu_req && !bus.cpu_flush;
  assign miss_start = accept && !lookup_hit;
  // An acknowledge is only meaningful while a refill is outstanding
  assign refill_ack = (state_reg == S_REFILL) && bus.mem_ack;
  assign last_beat  = (beat_reg == {OFF_W{1'b1}});
  assign fill_done  = refill_ack && last_beat;
  assign crit_beat  = (beat_reg == cap_off_reg);

  // ROM address is built from the captured request, so later CPU address
  // changes cannot disturb a refill that is in progress
  assign bus.mem_req    = (state_reg == S_REFILL);
  assign bus.mem_addr   = (state_reg == S_REFILL) ?
                          {cap_tag_reg, cap_idx_reg, beat_reg, 2'b00} : '0;
  assign bus.cpu_ready  = cpu_ready_reg;
  assign bus.cpu_instr  = cpu_instr_reg;
  assign bus.hit_count  = hit_count_reg;
  assign bus.miss_count = miss_count_reg;

  // Per-line valid bits: cleared by reset or flush, dropped when a line starts
  // refilling, set when the refill completes unless a flush hit it on the way
  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      // Valid flag of line gi
      always_ff @(posedge iCLK) begin
        if (iRST) begin
          valid_reg[gi] <= 1'b0;
        end else if (bus.cpu_flush) begin
          valid_reg[gi] <= 1'b0;
        end else if (miss_start && (req_idx == IDX_W'(gi))) begin
          valid_reg[gi] <= 1'b0;
        end else if (fill_done && (cap_idx_reg == IDX_W'(gi)) && !flushed_reg) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Tag store: written once the last beat of a line has arrived
  always_ff @(posedge iCLK) begin
    if (fill_done) begin
      tag_mem[cap_idx_reg] <= cap_tag_reg;
    end
  end

  // Data store: one word written per acknowledged refill beat
  always_ff @(posedge iCLK) begin
    if (refill_ack) begin
      data_mem[{cap_idx_reg, beat_reg}] <= bus.mem_rdata;
    end
  end

  // Controller: lookup in IDLE, refill beats in REFILL, one-cycle reply in RESP
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_reg      <= S_IDLE;
      cap_tag_reg    <= '0;
      cap_idx_reg    <= '0;
      cap_off_reg    <= '0;
      beat_reg       <= '0;
      flushed_reg    <= 1'b0;
      crit_reg       <= '0;
      cpu_ready_reg  <= 1'b0;
      cpu_instr_reg  <= '0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      cpu_ready_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            cap_tag_reg <= req_tag;
            cap_idx_reg <= req_idx;
            cap_off_reg <= req_off;
            if (lookup_hit) begin
              cpu_ready_reg <= 1'b1;
              cpu_instr_reg <= data_mem[{req_idx, req_off}];
              hit_count_reg <= hit_count_reg + 32'd1;
            end else begin
              state_reg      <= S_REFILL;
              beat_reg       <= '0;
              flushed_reg    <= 1'b0;
              miss_count_reg <= miss_count_reg + 32'd1;
            end
          end
        end
        S_REFILL: begin
          if (bus.cpu_flush) begin
            flushed_reg <= 1'b1;
          end
          if (bus.mem_ack) begin
            // Keep the requested word aside; the line may not stay valid
            if (crit_beat) begin
              crit_reg <= bus.mem_rdata;
            end
            beat_reg <= beat_reg + OFF_W'(1);
            if (last_beat) begin
              // A flush in this same cycle is caught by the valid bits directly
              flushed_reg   <= flushed_reg | bus.cpu_flush;
              cpu_ready_reg <= 1'b1;
              cpu_instr_reg <= crit_beat ? bus.mem_rdata : crit_reg;
              state_reg     <= S_RESP;
            end
          end
        end
        S_RESP: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule
